// File: rtl/seq_add_pkg.sv
// Shared constants and FSM encoding for the slice-serial 32-bit add/sub arbiter.
package seq_add_pkg;
  localparam int SLICE_W  = 8;
  localparam int N_SLICES = 4;
  localparam int OP_W     = SLICE_W * N_SLICES;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/seq_add32_arb_fa8.sv
// 8-bit carry-lookahead adder: every carry is a flat sum-of-products of g/p/ci.
module G_FullAdder8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       ci,
  output logic [7:0] s,
  output logic       co
);
  logic [7:0] g;
  logic [7:0] p;
  logic [8:0] c;
  logic       acc;
  logic       prop;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    c    = '0;
    acc  = 1'b0;
    prop = 1'b0;
    c[0] = ci;
    for (int i = 0; i < 8; i++) begin
      acc  = g[i];
      prop = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        acc  = acc | (prop & g[j]);
        prop = prop & p[j];
      end
      c[i+1] = acc | (prop & ci);
    end
  end

  assign s  = p ^ c[7:0];
  assign co = c[8];
endmodule

// File: rtl/seq_add32_arb.sv
// Two-requester round-robin front end feeding a slice-serial 32-bit adder/subtractor
// that reuses one 8-bit CLA for all slices, LSB slice first.
module seq_add32_arb #(
  parameter int N_SLICES = seq_add_pkg::N_SLICES
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [1:0]                   req_valid,
  output logic [1:0]                   req_ready,
  input  logic [seq_add_pkg::OP_W-1:0] a0,
  input  logic [seq_add_pkg::OP_W-1:0] b0,
  input  logic                         sub0,
  input  logic [seq_add_pkg::OP_W-1:0] a1,
  input  logic [seq_add_pkg::OP_W-1:0] b1,
  input  logic                         sub1,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic                         res_id,
  output logic [seq_add_pkg::OP_W-1:0] res_sum,
  output logic                         res_co,
  output logic                         res_ovf
);
  import seq_add_pkg::*;

  localparam logic [1:0] LAST = 2'(N_SLICES - 1);

  state_t              state;
  state_t              state_nxt;
  logic [1:0]          cnt;
  logic                carry_q;
  logic                last_q;
  logic                gnt;
  logic                gnt_any;
  logic                accept;
  logic [OP_W-1:0]     a_p0;
  logic [OP_W-1:0]     b_p0;
  logic                sub_p0;
  logic [SLICE_W-1:0]  a_sl;
  logic [SLICE_W-1:0]  b_sl;
  logic                cin;
  logic [SLICE_W-1:0]  sl_sum;
  logic                sl_co;

  // Round-robin: with both valid, the requester not served last wins.
  always_comb begin
    gnt     = 1'b0;
    gnt_any = 1'b0;
    case (req_valid)
      2'b01:   begin gnt = 1'b0;    gnt_any = 1'b1; end
      2'b10:   begin gnt = 1'b1;    gnt_any = 1'b1; end
      2'b11:   begin gnt = ~last_q; gnt_any = 1'b1; end
      default: begin gnt = 1'b0;    gnt_any = 1'b0; end
    endcase
  end

  // rst gates req_ready so the async-reset IDLE state cannot advertise a grant.
  assign req_ready = (!rst && state == IDLE && gnt_any) ? (gnt ? 2'b10 : 2'b01) : 2'b00;
  assign accept    = |(req_valid & req_ready);
  assign res_valid = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CALC;
      CALC:    if (cnt == LAST) state_nxt = DONE;
      DONE:    if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Slice stage: one CLA pass per CALC cycle, carry chained through carry_q.
  assign a_sl = a_p0[{cnt, 3'b000} +: SLICE_W];
  assign b_sl = b_p0[{cnt, 3'b000} +: SLICE_W] ^ {SLICE_W{sub_p0}};
  assign cin  = (cnt == 2'd0) ? sub_p0 : carry_q;

  G_FullAdder8 u_fa8 (
    .a  (a_sl),
    .b  (b_sl),
    .ci (cin),
    .s  (sl_sum),
    .co (sl_co)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= 2'd0;
      carry_q <= 1'b0;
      last_q  <= 1'b1;
      a_p0    <= '0;
      b_p0    <= '0;
      sub_p0  <= 1'b0;
      res_id  <= 1'b0;
      res_sum <= '0;
      res_co  <= 1'b0;
      res_ovf <= 1'b0;
    end else begin
      if (accept) begin
        a_p0    <= gnt ? a1 : a0;
        b_p0    <= gnt ? b1 : b0;
        sub_p0  <= gnt ? sub1 : sub0;
        res_id  <= gnt;
        last_q  <= gnt;
        cnt     <= 2'd0;
        carry_q <= 1'b0;
      end
      if (state == CALC) begin
        cnt     <= cnt + 2'd1;
        carry_q <= sl_co;
        res_sum[{cnt, 3'b000} +: SLICE_W] <= sl_sum;
        if (cnt == LAST) begin
          res_co  <= sl_co;
          res_ovf <= (a_sl[SLICE_W-1] == b_sl[SLICE_W-1]) &&
                     (sl_sum[SLICE_W-1] != a_sl[SLICE_W-1]);
        end
      end
    end
  end
endmodule
